// File: rtl/tc_pkg.sv
// tc_pkg: shared definitions for the tc_timer programmable interval timer.
//   - FSM state encoding
//   - register word offsets within the timer window
//   - CTRL bit positions and MODE encodings
package tc_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StCnt  = 2'd2,
        StInt  = 2'd3
    } tc_state_e;

    // Register word offsets (byte address bits [3:2])
    localparam logic [1:0] OfsCtrl     = 2'd0;
    localparam logic [1:0] OfsPreset   = 2'd1;
    localparam logic [1:0] OfsCount    = 2'd2;
    localparam logic [1:0] OfsPrescale = 2'd3;

    // CTRL field positions
    localparam int unsigned CtrlEnBit   = 0;
    localparam int unsigned CtrlModeLsb = 1;
    localparam int unsigned CtrlModeMsb = 2;
    localparam int unsigned CtrlImBit   = 3;
    localparam int unsigned CtrlWidth   = 4;

    // MODE encodings; 1x decodes as one-shot
    localparam logic [1:0] ModeOneShot    = 2'b00;
    localparam logic [1:0] ModeAutoReload = 2'b01;

    function automatic logic is_auto_reload(input logic [1:0] mode);
        return mode == ModeAutoReload;
    endfunction

endpackage

// File: rtl/tc_prescaler.sv
// tc_prescaler: tick generator for the timer count-down (used only when TC_PRESCALE_EN
// is defined). Produces one tick every div+1 cycles; restart realigns the phase so the
// first tick after a restart comes div+1 cycles later.
//   clk     in   system clock
//   reset   in   synchronous, active-high
//   restart in   zero the phase counter
//   div     in   16-bit divide value (0 = tick every cycle)
//   tick    out  combinational tick strobe
module tc_prescaler (
    input  logic        clk,
    input  logic        reset,
    input  logic        restart,
    input  logic [15:0] div,
    output logic        tick
);

    logic [15:0] cnt_q;

    // >= rather than == so lowering div mid-run cannot make the counter wrap through 2^16
    assign tick = (cnt_q >= div);

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt_q <= 16'd0;
        end else if (tick) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: rtl/tc_timer.sv
// tc_timer: memory-mapped programmable interval timer feeding one CP0 hw_int bit.
// Counts down from PRESET; one-shot mode holds irq until a CTRL/PRESET write,
// auto-reload mode pulses irq for one cycle per period.
// Optional feature macro: TC_PRESCALE_EN (adds PRESCALE register at offset 3).
//   clk    in   system clock
//   reset  in   synchronous, active-high
//   addr   in   word offset within the timer window
//   we     in   bus write strobe (already address-qualified)
//   wd     in   write data
//   rd     out  read data, combinational from addr
//   irq    out  interrupt request
module tc_timer
    import tc_pkg::*;
#(
    parameter int unsigned BASE_OFS_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BASE_OFS_W-1:0] addr,
    input  logic                  we,
    input  logic [31:0]           wd,
    output logic [31:0]           rd,
    output logic                  irq
);

    tc_state_e             state_q;
    logic [CtrlWidth-1:0]  ctrl_q;
    logic [31:0]           preset_q;
    logic [31:0]           count_q;
    logic                  pend_q;

    logic wr_ctrl;
    logic wr_preset;
    logic auto_reload;
    logic step;

    assign wr_ctrl     = we && (addr == BASE_OFS_W'(OfsCtrl));
    assign wr_preset   = we && (addr == BASE_OFS_W'(OfsPreset));
    assign auto_reload = is_auto_reload(ctrl_q[CtrlModeMsb:CtrlModeLsb]);

`ifdef TC_PRESCALE_EN
    logic [15:0] prescale_q;
    logic        wr_prescale;
    logic        tick;

    assign wr_prescale = we && (addr == BASE_OFS_W'(OfsPrescale));

    // Both LOAD and the auto-reload INT cycle start a fresh count, so both realign the phase
    tc_prescaler u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .restart ((state_q == StLoad) || (state_q == StInt)),
        .div     (prescale_q),
        .tick    (tick)
    );

    assign step = tick;
`else
    assign step = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
`ifdef TC_PRESCALE_EN
            prescale_q <= '0;
`endif
        end else begin
            if (wr_ctrl) begin
                ctrl_q <= wd[CtrlWidth-1:0];
            end
            if (wr_preset) begin
                preset_q <= wd;
            end
`ifdef TC_PRESCALE_EN
            if (wr_prescale) begin
                prescale_q <= wd[15:0];
            end
`endif
            if (wr_ctrl || wr_preset) begin
                pend_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (ctrl_q[CtrlEnBit]) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    count_q <= preset_q;
                    state_q <= StCnt;
                end
                StCnt: begin
                    if (!ctrl_q[CtrlEnBit]) begin
                        state_q <= StIdle;
                    end else if (step) begin
                        if (count_q > 32'd1) begin
                            count_q <= count_q - 32'd1;
                        end else begin
                            count_q <= '0;
                            state_q <= StInt;
                            // One-shot pend is raised on entry so irq is high during INT;
                            // a coincident CTRL/PRESET write still clears it.
                            if (!auto_reload && !(wr_ctrl || wr_preset)) begin
                                pend_q <= 1'b1;
                            end
                        end
                    end
                end
                StInt: begin
                    if (auto_reload) begin
                        // The INT cycle performs the reload itself, giving an N+1 period
                        count_q <= preset_q;
                        state_q <= StCnt;
                    end else begin
                        // A coincident bus write to CTRL takes precedence over the EN clear
                        if (!wr_ctrl) begin
                            ctrl_q[CtrlEnBit] <= 1'b0;
                        end
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        rd = '0;
        case (addr)
            BASE_OFS_W'(OfsCtrl):   rd = {{(32 - CtrlWidth){1'b0}}, ctrl_q};
            BASE_OFS_W'(OfsPreset): rd = preset_q;
            BASE_OFS_W'(OfsCount):  rd = count_q;
`ifdef TC_PRESCALE_EN
            BASE_OFS_W'(OfsPrescale): rd = {16'd0, prescale_q};
`endif
            default: rd = '0;
        endcase
    end

    assign irq = ctrl_q[CtrlImBit] & (pend_q | ((state_q == StInt) & auto_reload));

endmodule

// File: tb/tb_tc_timer.sv
module tb_tc_timer;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    tc_timer #(.BASE_OFS_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wd    (wd),
        .rd    (rd),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic compare_front(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed=0x%08h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp)
            else begin
                errors++;
                $error("FAIL %s: observed=0x%08h expected=0x%08h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic expect_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        push_exp(tag, exp);
        addr = a;
        #1;
        compare_front(rd);
    endtask

    task automatic expect_irq(input string tag, input logic exp);
        push_exp(tag, {31'd0, exp});
        compare_front({31'd0, irq});
    endtask

    // Advance n active edges, leaving us 1ns past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Write lands on the next edge; returns 1ns after it
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        addr = a;
        wd   = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        logic [31:0] ar_cnt [4];
        ar_cnt = '{32'd0, 32'd3, 32'd2, 32'd1};

        reset = 1'b1;
        we    = 1'b0;
        addr  = 2'd0;
        wd    = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        expect_rd("reset_ctrl", 2'd0, 32'd0);
        expect_rd("reset_preset", 2'd1, 32'd0);
        expect_rd("reset_count", 2'd2, 32'd0);
        expect_irq("reset_irq", 1'b0);

        // CTRL upper bits read zero
        bus_write(2'd0, 32'hFFFF_FFF6);
        expect_rd("ctrl_mask", 2'd0, 32'h6);
        bus_write(2'd0, 32'h0);

        // One-shot, PRESET=5: irq after E7, held
        bus_write(2'd1, 32'd5);
        expect_rd("os_preset", 2'd1, 32'd5);
        bus_write(2'd0, 32'h9);
        step(6);
        expect_irq("os_irq_e6", 1'b0);
        expect_rd("os_count_e6", 2'd2, 32'd1);
        step(1);
        expect_irq("os_irq_e7", 1'b1);
        expect_rd("os_count_e7", 2'd2, 32'd0);
        step(1);
        expect_rd("os_ctrl_en_clr", 2'd0, 32'h8);
        step(3);
        expect_irq("os_irq_hold", 1'b1);
        bus_write(2'd0, 32'h8);
        expect_irq("os_irq_cleared", 1'b0);

        // Auto-reload, PRESET=3: first INT at E5, then every 4 cycles
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'hB);
        step(5);
        for (int k = 0; k < 8; k++) begin
            expect_irq($sformatf("ar_irq_%0d", k), (k % 4) == 0);
            expect_rd($sformatf("ar_count_%0d", k), 2'd2, ar_cnt[k % 4]);
            step(1);
        end
        // INT at E13; write at E14 reloads to 3 then E15 drops to IDLE
        bus_write(2'd0, 32'h0);
        step(3);
        expect_irq("ar_off_irq", 1'b0);

        // COUNT is read-only
        bus_write(2'd2, 32'h55);
        expect_rd("count_ro", 2'd2, 32'd3);

        // Pause and resume
        bus_write(2'd1, 32'd12);
        bus_write(2'd0, 32'h1);
        step(4);
        expect_rd("pause_count10", 2'd2, 32'd10);
        bus_write(2'd0, 32'h0);
        step(3);
        expect_rd("pause_frozen9", 2'd2, 32'd9);
        bus_write(2'd0, 32'h1);
        step(2);
        expect_rd("resume_reload", 2'd2, 32'd12);
        // PRESET write during CNT leaves the running count alone
        bus_write(2'd1, 32'd7);
        step(1);
        expect_rd("preset_mid_cnt", 2'd2, 32'd10);
        bus_write(2'd0, 32'h0);
        step(2);
        bus_write(2'd0, 32'h1);
        step(2);
        expect_rd("preset_next_load", 2'd2, 32'd7);
        bus_write(2'd0, 32'h0);
        step(2);

        // Masked one-shot expiry
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'h1);
        step(6);
        expect_irq("mask_irq", 1'b0);
        expect_rd("mask_ctrl", 2'd0, 32'h0);
        bus_write(2'd0, 32'h8);
        expect_irq("mask_unmask_irq", 1'b0);

        // PRESET=0: INT at E3
        bus_write(2'd1, 32'd0);
        bus_write(2'd0, 32'h9);
        step(2);
        expect_irq("p0_irq_e2", 1'b0);
        step(1);
        expect_irq("p0_irq_e3", 1'b1);
        bus_write(2'd1, 32'd0);
        expect_irq("p0_preset_clr", 1'b0);

        // Reset mid-count
        bus_write(2'd1, 32'd20);
        bus_write(2'd0, 32'hB);
        step(5);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        expect_rd("rst_mid_ctrl", 2'd0, 32'd0);
        expect_rd("rst_mid_preset", 2'd1, 32'd0);
        expect_rd("rst_mid_count", 2'd2, 32'd0);
        expect_irq("rst_mid_irq", 1'b0);

`ifdef TC_PRESCALE_EN
        // PRESCALE=1, PRESET=4: decrement every 2nd cycle, INT at E10 instead of E6
        bus_write(2'd3, 32'hFFFF_0001);
        expect_rd("ps_readback", 2'd3, 32'd1);
        bus_write(2'd1, 32'd4);
        bus_write(2'd0, 32'h9);
        step(3);
        expect_rd("ps_count_e3", 2'd2, 32'd4);
        step(1);
        expect_rd("ps_count_e4", 2'd2, 32'd3);
        step(5);
        expect_irq("ps_irq_e9", 1'b0);
        step(1);
        expect_irq("ps_irq_e10", 1'b1);
`else
        bus_write(2'd3, 32'h1234);
        expect_rd("ofs3_zero", 2'd3, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
